// File: rtl/multicycle_pkg.sv
// multicycle_pkg: opcodes, FSM state encodings and datapath select codes shared by control and datapath
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ANDI  = 6'h01;
    localparam logic [5:0] OP_ADDI  = 6'h02;
    localparam logic [5:0] OP_LW    = 6'h03;
    localparam logic [5:0] OP_SW    = 6'h04;
    localparam logic [5:0] OP_BEQ   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h06;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // The legal opcodes are exactly the contiguous range R-type..J
    function automatic logic is_legal(input logic [5:0] op);
        return op <= OP_J;
    endfunction

endpackage

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: five-state FETCH/DECODE/EXEC/MEM/WB controller with memory-wait timeout
module multicycle_control_unit #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_addr_sel,
    output logic       reg_dst,
    output logic       wb_sel,
    output logic       ext_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic       mem_err,
    output logic [2:0] state
);
    import multicycle_pkg::*;

    localparam int WW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    // Timeout fires in the MEM_WAIT_MAX-th consecutive not-ready cycle
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT_MAX - 1);

    state_e          state_q, state_d;
    logic            ext_op_q, ext_op_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            waiting, timeout;

    assign state  = state_q;
    assign ext_op = ext_op_q;

    // State, extender mode and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            ext_op_q <= 1'b0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            ext_op_q <= ext_op_d;
            wait_q   <= wait_d;
        end
    end

    // Next state, strobes and wait-counter update; counter is zero outside FETCH/MEM so every entry starts clean
    always_comb begin
        state_d      = state_q;
        ext_op_d     = ext_op_q;
        wait_d       = '0;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        mem_addr_sel = 1'b0;
        reg_dst      = 1'b0;
        wb_sel       = 1'b0;
        alu_src_b    = SRCB_REG;
        alu_op       = ALU_ADD;
        pc_src       = PC_ALU;
        illegal      = 1'b0;
        mem_err      = 1'b0;
        waiting      = (state_q == S_FETCH) || (state_q == S_MEM);
        timeout      = waiting && !mem_ready && (wait_q == WAIT_LAST);
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_op    = ALU_ADD;
                    pc_src    = PC_ALU;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                ext_op_d = (opcode != OP_ANDI);
                if (opcode == OP_J) begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                    state_d  = S_FETCH;
                end else if (!is_legal(opcode)) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
                case (opcode)
                    OP_RTYPE: alu_op = ALU_FUNCT;
                    OP_ANDI: begin
                        alu_src_b = SRCB_IMM;
                        alu_op    = ALU_AND;
                    end
                    OP_ADDI: alu_src_b = SRCB_IMM;
                    OP_LW, OP_SW: begin
                        alu_src_b = SRCB_IMM;
                        state_d   = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op   = ALU_SUB;
                        pc_src   = PC_BRANCH;
                        pc_write = zero;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_addr_sel = 1'b1;
                mem_read     = (opcode == OP_LW);
                mem_write    = (opcode == OP_SW) && !timeout;
                if (mem_ready)
                    state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
            end
            S_WB: begin
                reg_write = 1'b1;
                reg_dst   = (opcode == OP_RTYPE);
                wb_sel    = (opcode == OP_LW);
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (waiting && !mem_ready) begin
            wait_d = wait_q + WW'(1);
            if (timeout) begin
                wait_d  = '0;
                mem_err = 1'b1;
                state_d = S_FETCH;
            end
        end
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15: the maximum number of mem_ready wait cycles in FETCH or MEM before timeout.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port opcode, input, 6 bits: instr[31:26] from the instruction register.
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag, used for BEQ.
REQ-006 SHALL have port mem_ready, input, 1 bit: memory access complete in the current cycle.
REQ-007 SHALL have outputs pc_write, ir_write, mem_read, mem_write and reg_write, each 1 bit: register and memory write/read strobes.
REQ-008 SHALL have outputs mem_addr_sel, reg_dst and wb_sel, each 1 bit: mem_addr_sel 0=PC/1=ALU; reg_dst 0=rt/1=rd; wb_sel 0=ALU/1=memory.
REQ-009 SHALL have output ext_op, 1 bit: immediate extender mode, 0=zero-extend, 1=sign-extend.
REQ-010 SHALL have outputs alu_src_b, alu_op and pc_src, each 2 bits: alu_src_b 00=reg,01=const 4,10=ext imm; alu_op 00=add,01=sub,10=funct,11=and; pc_src 00=ALU,01=branch target,10=jump target.
REQ-011 SHALL have outputs illegal and mem_err, each 1 bit and each a single-cycle pulse; SHALL have output state, 3 bits: the current FSM state.

Function
REQ-012 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next edge with all strobes at 0.
REQ-013 SHALL decode opcodes as: 00 R-type, 01 ANDI, 02 ADDI, 03 LW, 04 SW, 05 BEQ, 06 J; every other opcode is illegal.
REQ-014 In FETCH, SHALL drive mem_read=1 and mem_addr_sel=0; on mem_ready=1, SHALL in the same cycle drive ir_write=1, pc_write=1, alu_src_b=01, alu_op=00 and pc_src=00, then go to DECODE.
REQ-015 In DECODE, SHALL register ext_op as 0 for ANDI and 1 for all other opcodes; ext_op SHALL hold its value until the next DECODE.
REQ-016 In DECODE, for J SHALL drive pc_write=1 and pc_src=10, then go to FETCH.
REQ-017 In DECODE, for an illegal opcode SHALL pulse illegal=1 for one cycle, make no writes, and go to FETCH.
REQ-018 From DECODE, all other legal opcodes SHALL go to EXEC.
REQ-019 In EXEC, SHALL drive: R-type alu_src_b=00, alu_op=10; ANDI alu_src_b=10, alu_op=11; ADDI, LW and SW alu_src_b=10, alu_op=00; BEQ alu_src_b=00, alu_op=01, pc_src=01, with pc_write=zero in the same cycle.
REQ-020 From EXEC, BEQ SHALL go to FETCH, LW and SW SHALL go to MEM, and all others SHALL go to WB.
REQ-021 In MEM, SHALL drive mem_addr_sel=1 and mem_read=1 (LW) or mem_write=1 (SW), held until mem_ready.
REQ-022 On mem_ready in MEM, LW SHALL go to WB and SW SHALL go to FETCH.
REQ-023 In WB, SHALL drive reg_write=1 for exactly one cycle, with reg_dst=1 for R-type else 0, and wb_sel=1 for LW else 0; then go to FETCH.
REQ-024 Latency with mem_ready tied to 1 SHALL be: J 2 cycles; BEQ 3; R-type, ANDI, ADDI and SW 4; LW 5.
REQ-025 A wait counter SHALL clear on every entry to FETCH or MEM and increment each cycle that mem_ready=0.
REQ-026 When the wait counter reaches MEM_WAIT_MAX with mem_ready=0, SHALL pulse mem_err for one cycle, suppress all writes, and go to FETCH.
REQ-027 If mem_ready=1 arrives in the same cycle the wait counter reaches MEM_WAIT_MAX, mem_ready SHALL win and no mem_err SHALL be raised.
REQ-028 Every output not listed for a state SHALL be 0 in that state, except ext_op, which is registered.

Reset
REQ-029 Assertion of rst_n=0 SHALL immediately force state=FETCH, ext_op=0, wait counter=0, and illegal=mem_err=0.
REQ-030 Reset asserted mid-instruction SHALL abort the instruction with no further writes.
REQ-031 The first FETCH SHALL begin on the first clk edge after rst_n rises.

Structure
REQ-032 Opcode constants, state encodings, and the alu_op, alu_src_b and pc_src codes SHALL be defined in a shared package, multicycle_pkg, reused by the datapath.
REQ-033 The block SHALL consist of a single FSM module with no sub-module, plus an inline wait counter of width $clog2(MEM_WAIT_MAX+1).

Verification
REQ-034 ADDI with mem_ready=1: state sequence 0,1,2,4,0; ext_op=1 from DECODE onward; reg_write=1 in WB only; wb_sel=0.
REQ-035 ANDI following ADDI: ext_op falls to 0 at DECODE exit; alu_op=11 in EXEC.
REQ-036 BEQ: with zero=1, pc_write=1 and pc_src=01 in EXEC; with zero=0, pc_write=0; state returns to 0 after 3 cycles.
REQ-037 LW with mem_ready low for 3 MEM cycles: mem_read held for 4 cycles, then WB with wb_sel=1 and reg_write=1; no mem_err.
REQ-038 mem_ready held 0 in FETCH: mem_err pulses once at cycle 15, ir_write stays 0, FETCH restarts, and the counter is back at 0.
REQ-039 Opcode 0x3F: illegal pulses once in DECODE; rst_n dropped during MEM of SW: mem_write falls immediately and state=0.
